cpu_trace_emitter: RTL and testbench
====================================

# cpu_trace_emitter

Serialises CPU write-back events into the ASCII trace character stream that the `cpu_checker` format checker consumes, one character per clock. A register write becomes `^<time>@<pc>: $<reg> <= <data>#` and a memory write becomes `^<time>@<pc>: *<addr> <= <data>#`. The block sits directly upstream of the checker: `char_out` drives the checker's `char` input, and both share `clk`/`reset`. Every record it emits must make the checker report the matching format type on the `#` cycle.

## Interface
- No parameters; all field widths are fixed by the trace format.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; forces IDLE.
- `req_valid`  in  1  an event is presented.
- `req_ready`  out  1  the block accepts the event this cycle. Combinational from state.
- `req_type`  in  1  0 = register write, 1 = memory write.
- `req_time`  in  14  event time, unsigned binary.
- `req_pc`  in  32  PC of the writing instruction.
- `req_reg`  in  5  destination register number; used when `req_type`=0.
- `req_addr`  in  32  store address; used when `req_type`=1.
- `req_data`  in  32  written value.
- `char_out`  out  8  current trace character (registered).
- `char_valid`  out  1  `char_out` holds a record character (registered).
- `busy`  out  1  a record is being emitted; equals `char_valid`.

## Operation
- **Handshake:** an event is accepted on the rising edge where `req_valid` and `req_ready` are both 1. All `req_*` fields are captured into internal registers on that edge; later changes to the inputs are ignored.
- **Field encoding:**
  - time: decimal, leading zeros suppressed; 0 emits `0`. Values above 9999 saturate to 9999, because the checker allows at most 4 digits.
  - pc, addr, data: exactly 8 lowercase hex digits, most significant digit first.
  - reg: decimal without leading zero, `0`..`31`.
  - separators are literal: `@`, then `:` followed by one space, then `$` or `*`, then ` <= ` (space, `<`, `=`, space), then `#`.
- **State machine** (each non-IDLE state emits its character(s), then advances):
  - IDLE → CARET on accept.
  - CARET `^` → TIME (1–4 digits) → AT `@` → PC (8 digits) → COLON `:` → SP `' '`.
  - SP → PREFIX, which emits `$` if type 0 or `*` if type 1.
  - PREFIX → REG (1–2 digits) if type 0, or ADDR (8 digits) if type 1.
  - REG or ADDR → SP2 `' '` → LT `<` → EQ `=` → SP3 `' '` → DATA (8 digits) → SHARP `#`.
  - SHARP → CARET if an event is accepted in that cycle, otherwise IDLE.
- **Digit counter:** a 4-bit counter indexes the digit position within multi-digit fields. Decimal digits come from the saturated time and from the register number, via /10 and %10 arithmetic on the captured values.
- **Idle output:** while IDLE, `char_out`=8'h00 and `char_valid`=0. 8'h00 matches no checker token, so idle cycles leave the checker in its reset-equivalent state.

## Timing
- **Reset:** `char_out`=8'h00, `char_valid`=0, `busy`=0. State is IDLE, so `req_ready`=1 in the first cycle after reset.
- **Accept latency:** for an event accepted at edge E, `^` is on `char_out` during the cycle after E and is sampled by the checker at edge E+1. Each following character comes on the next cycle, with no gaps.
- **`req_ready`** = 1 in IDLE and in SHARP (the `#` cycle), 0 in all other states.
- **Back-to-back records:** an event accepted during SHARP puts the next record's `^` directly after `#`, with zero idle cycles. The checker's `#`→`^` transition supports this.
- **Record length** (T = number of time digits, R = number of reg digits): register write = T+R+26 cycles; memory write = T+34 cycles.
- **Reset mid-record:** takes effect at the next edge. The output goes to 8'h00 with `char_valid`=0, the partial record is abandoned and never resumed, and no event is accepted in that cycle.
- **`req_valid` while `req_ready`=0:** ignored (not queued). The producer must hold the event until it is accepted.

## Test plan
- **Register write:** time=5, pc=0x00003000, reg=3, data=0x12. Required: exactly the 28-character stream `^5@00003000: $3 <= 00000012#`, `^` one cycle after accept; checker `format_type`=2'b01 on the `#` cycle.
- **Memory write:** time=1234, pc=0xdeadbeef, addr=0x0000abcd, data=0xffffffff. Required: `^1234@deadbeef: *0000abcd <= ffffffff#` (38 characters); checker reports 2'b10.
- **Edge values:** time=0, reg=0, then time=12345, reg=31. Required: `^0@...$0 <= ...#`, then `^9999@...$31 <= ...#`.
- **Back-to-back:** `req_valid` held high with two events. Required: the second `^` immediately follows the first `#`; `req_ready` is high only in IDLE and on the `#` cycles; checker pulses twice.
- **Reset mid-record:** `reset` asserted during the PC digits. Required: `char_out`=8'h00 and `req_ready`=1 the next cycle; a new event afterwards emits a complete, correct record.
- **Input stability:** change `req_*` after accept. Required: the emitted record reflects the values captured at accept.

Source files
------------

// File: rtl/cpu_trace_emitter.sv
// Serialises CPU write-back events into the ASCII trace stream read by cpu_checker,
// one character per clock: "^<time>@<pc>: $<reg> <= <data>#" or "... *<addr> ...".
module cpu_trace_emitter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_type,
   input  logic [13:0] req_time,
   input  logic [31:0] req_pc,
   input  logic [4:0]  req_reg,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   output logic [7:0]  char_out,
   output logic        char_valid,
   output logic        busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP, S_PREFIX,
      S_REG, S_ADDR, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_SHARP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        type_q, type_d;
   logic [13:0] time_q, time_d;
   logic [31:0] pc_q, pc_d;
   logic [4:0]  reg_q, reg_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [7:0]  char_d;
   logic        accept;

   // Index of the last decimal digit of a time value already clamped to 9999.
   function automatic logic [1:0] time_last(input logic [13:0] t);
      if (t >= 14'd1000)     return 2'd3;
      else if (t >= 14'd100) return 2'd2;
      else if (t >= 14'd10)  return 2'd1;
      else                   return 2'd0;
   endfunction

   function automatic logic [3:0] time_digit(input logic [13:0] t, input logic [1:0] pos);
      logic [1:0]  e;
      logic [13:0] q;
      e = time_last(t) - pos;
      case (e)
         2'd0:    q = t % 14'd10;
         2'd1:    q = (t / 14'd10) % 14'd10;
         2'd2:    q = (t / 14'd100) % 14'd10;
         default: q = t / 14'd1000;
      endcase
      return q[3:0];
   endfunction

   function automatic logic [3:0] reg_digit(input logic [4:0] r, input logic pos);
      logic [4:0] q;
      if (!pos && r >= 5'd10) q = r / 5'd10;
      else                    q = r % 5'd10;
      return q[3:0];
   endfunction

   function automatic logic [7:0] dec_char(input logic [3:0] v);
      return 8'h30 + {4'h0, v};
   endfunction

   function automatic logic [7:0] hex_char(input logic [31:0] v, input logic [2:0] pos);
      logic [31:0] s;
      s = v >> {~pos, 2'b00};
      return (s[3:0] < 4'd10) ? dec_char(s[3:0]) : 8'h57 + {4'h0, s[3:0]};
   endfunction

   function automatic logic [7:0] field_char(
      input state_t s, input logic [3:0] cnt, input logic typ, input logic [13:0] t,
      input logic [31:0] pc, input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
      case (s)
         S_CARET:  return "^";
         S_TIME:   return dec_char(time_digit(t, cnt[1:0]));
         S_AT:     return "@";
         S_PC:     return hex_char(pc, cnt[2:0]);
         S_COLON:  return ":";
         S_PREFIX: return typ ? "*" : "$";
         S_REG:    return dec_char(reg_digit(r, cnt[0]));
         S_ADDR:   return hex_char(a, cnt[2:0]);
         S_LT:     return "<";
         S_EQ:     return "=";
         S_SP, S_SP2, S_SP3: return " ";
         S_DATA:   return hex_char(d, cnt[2:0]);
         S_SHARP:  return "#";
         default:  return 8'h00;
      endcase
   endfunction

   assign req_ready = (state_q == S_IDLE) || (state_q == S_SHARP);
   assign accept    = req_valid && req_ready;
   assign busy      = char_valid;

   // The output register is loaded from the *next* state so '^' appears the cycle after accept.
   always_comb begin
      // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = 4'd0;
      type_d  = accept ? req_type : type_q;
      time_d  = accept ? ((req_time > 14'd9999) ? 14'd9999 : req_time) : time_q;
      pc_d    = accept ? req_pc   : pc_q;
      reg_d   = accept ? req_reg  : reg_q;
      addr_d  = accept ? req_addr : addr_q;
      data_d  = accept ? req_data : data_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_CARET;
         S_CARET:  state_d = S_TIME;
         S_TIME:   if (cnt_q == {2'b00, time_last(time_q)}) state_d = S_AT;
                   else cnt_d = cnt_q + 4'd1;
         S_AT:     state_d = S_PC;
         S_PC:     if (cnt_q == 4'd7) state_d = S_COLON;
                   else cnt_d = cnt_q + 4'd1;
         S_COLON:  state_d = S_SP;
         S_SP:     state_d = S_PREFIX;
         S_PREFIX: state_d = type_q ? S_ADDR : S_REG;
         S_REG:    if (cnt_q == {3'b000, reg_q >= 5'd10}) state_d = S_SP2;
                   else cnt_d = cnt_q + 4'd1;
         S_ADDR:   if (cnt_q == 4'd7) state_d = S_SP2;
                   else cnt_d = cnt_q + 4'd1;
         S_SP2:    state_d = S_LT;
         S_LT:     state_d = S_EQ;
         S_EQ:     state_d = S_SP3;
         S_SP3:    state_d = S_DATA;
         S_DATA:   if (cnt_q == 4'd7) state_d = S_SHARP;
                   else cnt_d = cnt_q + 4'd1;
         S_SHARP:  state_d = accept ? S_CARET : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      char_d = field_char(state_d, cnt_d, type_d, time_d, pc_d, reg_d, addr_d, data_d);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         char_out   <= 8'h00;
         char_valid <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         char_out   <= char_d;
         char_valid <= (state_d != S_IDLE);
      end
   end

   // NOTE: the captured event fields need no reset; they are only read after an accept loads them.
   always_ff @(posedge clk) begin
      if (!reset) begin
         type_q <= type_d;
         time_q <= time_d;
         pc_q   <= pc_d;
         reg_q  <= reg_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed bench for cpu_trace_emitter: compares each emitted record with a hand-written
// expected trace string and checks the handshake and idle/reset behaviour.
module tb_cpu_trace_emitter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_type;
   logic [13:0] req_time;
   logic [31:0] req_pc;
   logic [4:0]  req_reg;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [7:0]  char_out;
   logic        char_valid;
   logic        busy;

   int passed = 0;
   int total  = 0;

   cpu_trace_emitter dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_type   (req_type),
      .req_time   (req_time),
      .req_pc     (req_pc),
      .req_reg    (req_reg),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .char_out   (char_out),
      .char_valid (char_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Presents an event at a falling edge and returns 1 time unit after the accepting rising edge.
   task automatic drive_event(input logic typ, input logic [13:0] t, input logic [31:0] pc,
                              input logic [4:0] r, input logic [31:0] a, input logic [31:0] d,
                              input bit hold);
      int waited = 0;
      @(negedge clk);
      req_type = typ; req_time = t; req_pc = pc; req_reg = r; req_addr = a; req_data = d;
      req_valid = 1'b1;
      while (!req_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (req_ready !== 1'b1) $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
      else passed++;
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   // Samples len characters at falling edges; counts cycles with bad valid/busy or bad req_ready.
   task automatic collect(input string exp, input int release_at, output string got,
                          output int bad_valid, output int bad_ready);
      got = ""; bad_valid = 0; bad_ready = 0;
      for (int i = 0; i < exp.len(); i++) begin
         @(negedge clk);
         got = {got, $sformatf("%c", char_out)};
         if (char_valid !== 1'b1 || busy !== 1'b1) bad_valid++;
         if (req_ready !== (exp[i] == "#")) bad_ready++;
         if (i == release_at) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; req_type = 1'b0; req_time = '0;
      req_pc = '0; req_reg = '0; req_addr = '0; req_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (char_out !== 8'h00) $display("FAIL reset_char: got %h required 00", char_out); else passed++;
      total++; if (char_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", char_valid); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
      reset = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", req_ready); else passed++;
      total++; if (char_valid !== 1'b0) $display("FAIL idle_valid: got %b required 0", char_valid); else passed++;
   endtask

   task automatic test_reg_write();
      string exp = "^5@00003000: $3 <= 00000012#";
      string got; int bv, br;
      drive_event(1'b0, 14'd5, 32'h0000_3000, 5'd3, 32'h5555_aaaa, 32'h0000_0012, 1'b0);
      collect(exp, -1, got, bv, br);
      total++; if (got != exp) $display("FAIL reg_write_text: got \"%s\" required \"%s\"", got, exp); else passed++;
      total++; if (bv != 0) $display("FAIL reg_write_valid: %0d bad cycles, required 0", bv); else passed++;
      total++; if (br != 0) $display("FAIL reg_write_ready: %0d bad cycles, required 0", br); else passed++;
      @(negedge clk);
      total++; if (char_out !== 8'h00 || char_valid !== 1'b0)
         $display("FAIL reg_write_idle: char=%h valid=%b required 00/0", char_out, char_valid); else passed++;
      total++; if (req_ready !== 1'b1) $display("FAIL reg_write_idle_ready: got %b required 1", req_ready); else passed++;
   endtask

   task automatic test_mem_write();
      string exp = "^1234@deadbeef: *0000abcd <= ffffffff#";
      string got; int bv, br;
      drive_event(1'b1, 14'd1234, 32'hdead_beef, 5'd9, 32'h0000_abcd, 32'hffff_ffff, 1'b0);
      collect(exp, -1, got, bv, br);
      total++; if (got != exp) $display("FAIL mem_write_text: got \"%s\" required \"%s\"", got, exp); else passed++;
      total++; if (bv != 0 || br != 0) $display("FAIL mem_write_flags: valid errs %0d ready errs %0d, required 0", bv, br); else passed++;
   endtask

   task automatic test_edge_values();
      string exp0 = "^0@00000010: $0 <= cafef00d#";
      string exp1 = "^9999@89abcdef: $31 <= 01234567#";
      string got; int bv, br;
      drive_event(1'b0, 14'd0, 32'h0000_0010, 5'd0, 32'h0, 32'hcafe_f00d, 1'b0);
      collect(exp0, -1, got, bv, br);
      total++; if (got != exp0 || bv != 0) $display("FAIL edge_zero: got \"%s\" (valid errs %0d) required \"%s\"", got, bv, exp0); else passed++;
      drive_event(1'b0, 14'd12345, 32'h89ab_cdef, 5'd31, 32'h0, 32'h0123_4567, 1'b0);
      collect(exp1, -1, got, bv, br);
      total++; if (got != exp1 || bv != 0) $display("FAIL edge_saturate: got \"%s\" (valid errs %0d) required \"%s\"", got, bv, exp1); else passed++;
   endtask

   task automatic test_back_to_back();
      string exp1 = "^7@00000010: $1 <= 0000000a#";
      string exp2 = "^100@00000014: *00002000 <= 0000000b#";
      string got; int bv, br;
      drive_event(1'b0, 14'd7, 32'h0000_0010, 5'd1, 32'h0, 32'h0000_000a, 1'b1);
      req_type = 1'b1; req_time = 14'd100; req_pc = 32'h0000_0014;
      req_reg = 5'd4; req_addr = 32'h0000_2000; req_data = 32'h0000_000b;
      collect({exp1, exp2}, exp1.len() - 1, got, bv, br);
      total++; if (got != {exp1, exp2}) $display("FAIL b2b_text: got \"%s\" required \"%s%s\"", got, exp1, exp2); else passed++;
      total++; if (bv != 0) $display("FAIL b2b_gapless: %0d cycles without char_valid, required 0", bv); else passed++;
      total++; if (br != 0) $display("FAIL b2b_ready: %0d cycles with wrong req_ready, required 0", br); else passed++;
      @(negedge clk);
      total++; if (char_valid !== 1'b0) $display("FAIL b2b_end_idle: valid=%b required 0", char_valid); else passed++;
   endtask

   task automatic test_reset_mid_record();
      string exp = "^3@00000040: *00000080 <= 0000001f#";
      string got; int bv, br;
      drive_event(1'b1, 14'd77, 32'hcafe_babe, 5'd0, 32'h1, 32'h2, 1'b0);
      repeat (6) @(negedge clk);
      total++; if (char_out !== "a") $display("FAIL midrec_pc_digit: got %h required 61", char_out); else passed++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++; if (char_out !== 8'h00 || char_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL midrec_reset_out: char=%h valid=%b busy=%b required 00/0/0", char_out, char_valid, busy); else passed++;
      total++; if (req_ready !== 1'b1) $display("FAIL midrec_reset_ready: got %b required 1", req_ready); else passed++;
      @(negedge clk);
      total++; if (char_valid !== 1'b0) $display("FAIL midrec_no_resume: valid=%b required 0", char_valid); else passed++;
      drive_event(1'b1, 14'd3, 32'h0000_0040, 5'd0, 32'h0000_0080, 32'h0000_001f, 1'b0);
      collect(exp, -1, got, bv, br);
      total++; if (got != exp || bv != 0) $display("FAIL midrec_after: got \"%s\" required \"%s\"", got, exp); else passed++;
   endtask

   task automatic test_input_stability();
      string exp = "^42@00000100: $17 <= 0000beef#";
      string got; int bv, br;
      drive_event(1'b0, 14'd42, 32'h0000_0100, 5'd17, 32'h0, 32'h0000_beef, 1'b0);
      req_type = 1'b1; req_time = 14'd9; req_pc = 32'hffff_ffff;
      req_reg = 5'd2; req_addr = 32'h1111_1111; req_data = 32'h0;
      collect(exp, -1, got, bv, br);
      total++; if (got != exp) $display("FAIL stability_text: got \"%s\" required \"%s\"", got, exp); else passed++;
   endtask

   initial begin
      test_reset();
      test_reg_write();
      test_mem_write();
      test_edge_values();
      test_back_to_back();
      test_reset_mid_record();
      test_input_stability();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
